descrypt_cmp: RTL and testbench

DESCRYPT_CMP -- requirements
Module: descrypt_cmp

---
 rtl/descrypt_cmp.sv | 277 +++++++++++++++++++++++++++
 tb/tb_descrypt_cmp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/descrypt_cmp.sv
// descrypt_cmp: batch comparator for computed descrypt hashes.
//
// Each batch holds NUM_INSTANCES keys in the write bank of a 2-bank result buffer. cmp_start
// hands that bank to the search engine. For every key, the engine runs a binary search over a
// sorted hash table. It emits a serialized frame per match, and one final frame per batch.
//
// Frame layout (DOUT_WIDTH-bit words, LSB-first, zero-extended):
//   header {tag, 1}, flags {key_valid, equal, last}
//   on a match: instance index words, table address words, one zero word
//
// Optional feature: define CMP_MATCH_COUNT_EN to append the batch's match count after the
// final frame of each batch.
//
// Ports:
//   CMP_CLK, RST           clock; asynchronous active-high reset
//   ram_wr_*               hash table write port, data = {hash_valid, hash}
//   read_addr_start        binary search start address
//   addr_diff_start        binary search initial step
//   res_wr_*               result buffer write port (write bank), data = {key_valid, hash}
//   cmp_start, cmp_tag     batch start pulse and its tag
//   cmp_ready              engine idle, cmp_start will be accepted
//   dout_ready             downstream may accept a new frame
//   dout                   frame words, 0 when idle
//   cmp_error              sticky: cmp_start seen while not ready
module descrypt_cmp #(
  parameter int NUM_INSTANCES  = 16,
  parameter int HASH_WIDTH     = 35,
  parameter int RAM_ADDR_WIDTH = 12,
  parameter int DOUT_WIDTH     = 4,
  parameter int TAG_WIDTH      = 3
) (
  input  logic                      CMP_CLK,
  input  logic                      RST,
  input  logic                      ram_wr_en,
  input  logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  input  logic [HASH_WIDTH:0]       ram_wr_data,
  input  logic [RAM_ADDR_WIDTH-1:0] read_addr_start,
  input  logic [RAM_ADDR_WIDTH-1:0] addr_diff_start,
  input  logic                      res_wr_en,
  input  logic [$clog2(NUM_INSTANCES)-1:0] res_wr_addr,
  input  logic [HASH_WIDTH:0]       res_wr_data,
  input  logic                      cmp_start,
  input  logic [TAG_WIDTH-1:0]      cmp_tag,
  output logic                      cmp_ready,
  input  logic                      dout_ready,
  output logic [DOUT_WIDTH-1:0]     dout,
  output logic                      cmp_error
);

  localparam int IW       = $clog2(NUM_INSTANCES);
  localparam int IW_WORDS = (IW + DOUT_WIDTH - 1) / DOUT_WIDTH;
  localparam int AW_WORDS = (RAM_ADDR_WIDTH + DOUT_WIDTH - 1) / DOUT_WIDTH;
  localparam int EQ_WORDS = 3 + IW_WORDS + AW_WORDS;
`ifdef CMP_MATCH_COUNT_EN
  localparam int CNT_W     = $clog2(NUM_INSTANCES + 1);
  localparam int CNT_WORDS = (CNT_W + DOUT_WIDTH - 1) / DOUT_WIDTH;
`else
  localparam int CNT_WORDS = 0;
`endif
  localparam int FRAME_WORDS = EQ_WORDS + CNT_WORDS;
  localparam int FRAME_W     = FRAME_WORDS * DOUT_WIDTH;
  localparam int LEN_W       = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {StIdle, StStart, StRead, StCompare} state_t;

  state_t                    state_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [RAM_ADDR_WIDTH-1:0] diff_q, diff_nxt;
  logic [IW-1:0]             inst_q, inst_nxt;
  logic                      rd_bank_q, bank_nxt;
  logic                      wr_bank_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic                      cmp_ready_q, cmp_error_q;
  logic [DOUT_WIDTH-1:0]     dout_q;
  logic                      dout_ready_q;
  logic [HASH_WIDTH:0]       hash_q, key_q;
  logic                      busy_q;  // frame latched, waiting for or in transmission
  logic                      send_q;  // frame transmission in progress
  logic [FRAME_W-1:0]        frame_q, frame_nxt;
  logic [LEN_W-1:0]          frame_len_q, len_nxt;
`ifdef CMP_MATCH_COUNT_EN
  logic [CNT_W-1:0]          match_cnt_q;
  logic [CNT_WORDS*DOUT_WIDTH-1:0] cnt_w;
`endif

  // Memories: synchronous read, never reset.
  logic [HASH_WIDTH:0] hash_mem [2**RAM_ADDR_WIDTH];
  logic [HASH_WIDTH:0] res_mem  [2*NUM_INSTANCES];
  logic [HASH_WIDTH:0] ram_rd_q, res_rd_q;

  // Reads use next-cycle addresses so that data issued on a transition into StRead (or
  // StStart) is valid during StRead.
  always_ff @(posedge CMP_CLK) begin
    if (ram_wr_en) hash_mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_q <= hash_mem[addr_nxt];
  end

  // wr_bank_q is the pre-toggle value even on the cycle a start is accepted.
  always_ff @(posedge CMP_CLK) begin
    if (res_wr_en) res_mem[{wr_bank_q, res_wr_addr}] <= res_wr_data;
    res_rd_q <= res_mem[{bank_nxt, inst_nxt}];
  end

  logic                  key_valid, hash_valid, equal, last, search_done, go_down;
  logic                  accept, emit, frame_end;
  logic [DOUT_WIDTH-1:0] hdr_w, flags_w;
  logic [IW_WORDS*DOUT_WIDTH-1:0] inst_w;
  logic [AW_WORDS*DOUT_WIDTH-1:0] addr_w;

  assign key_valid   = key_q[HASH_WIDTH];
  assign hash_valid  = hash_q[HASH_WIDTH];
  assign equal       = key_valid & hash_valid &
                       (key_q[HASH_WIDTH-1:0] == hash_q[HASH_WIDTH-1:0]);
  assign last        = (inst_q == IW'(NUM_INSTANCES - 1));
  assign search_done = equal | (diff_q == '0) | ~key_valid;
  assign go_down     = ~hash_valid | (key_q[HASH_WIDTH-1:0] < hash_q[HASH_WIDTH-1:0]);
  assign accept      = cmp_start & cmp_ready_q;
  assign emit        = busy_q & (send_q | dout_ready_q);
  assign frame_end   = emit & (frame_len_q == LEN_W'(1));

  // Datapath next state: search address, step, instance and read bank.
  always_comb begin
    addr_nxt = addr_q;
    diff_nxt = diff_q;
    inst_nxt = inst_q;
    bank_nxt = rd_bank_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          addr_nxt = read_addr_start;
          diff_nxt = addr_diff_start;
          inst_nxt = '0;
          bank_nxt = wr_bank_q;
        end
      end
      StCompare: begin
        if (!busy_q) begin
          if (!search_done) begin
            addr_nxt = go_down ? addr_q - diff_q : addr_q + diff_q;
            diff_nxt = diff_q >> 1;
          end else if (!equal && !last) begin
            inst_nxt = inst_q + IW'(1);
            addr_nxt = read_addr_start;
            diff_nxt = addr_diff_start;
          end
        end else if (frame_end) begin
          if (last) begin
            bank_nxt = ~rd_bank_q;
          end else begin
            inst_nxt = inst_q + IW'(1);
            addr_nxt = read_addr_start;
            diff_nxt = addr_diff_start;
          end
        end
      end
      default: ;
    endcase
  end

  // Frame assembly for the instance currently in StCompare.
  always_comb begin
    hdr_w                  = '0;
    hdr_w[TAG_WIDTH:0]     = {tag_q, 1'b1};
    flags_w                = '0;
    flags_w[2:0]           = {key_valid, equal, last};
    inst_w                 = '0;
    inst_w[IW-1:0]         = inst_q;
    addr_w                 = '0;
    addr_w[RAM_ADDR_WIDTH-1:0] = addr_q;
    frame_nxt              = '0;
    if (equal) begin
      frame_nxt[EQ_WORDS*DOUT_WIDTH-1:0] = {{DOUT_WIDTH{1'b0}}, addr_w, inst_w, flags_w, hdr_w};
      len_nxt = LEN_W'(EQ_WORDS);
    end else begin
      frame_nxt[2*DOUT_WIDTH-1:0] = {flags_w, hdr_w};
      len_nxt = LEN_W'(2);
    end
`ifdef CMP_MATCH_COUNT_EN
    cnt_w            = '0;
    cnt_w[CNT_W-1:0] = match_cnt_q + CNT_W'(equal);
    if (last) begin
      if (equal) frame_nxt[EQ_WORDS*DOUT_WIDTH +: CNT_WORDS*DOUT_WIDTH] = cnt_w;
      else       frame_nxt[2*DOUT_WIDTH +: CNT_WORDS*DOUT_WIDTH] = cnt_w;
      len_nxt = len_nxt + LEN_W'(CNT_WORDS);
    end
`endif
  end

  always_ff @(posedge CMP_CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      diff_q       <= '0;
      inst_q       <= '0;
      rd_bank_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      tag_q        <= '0;
      cmp_ready_q  <= 1'b1;
      cmp_error_q  <= 1'b0;
      dout_q       <= '0;
      dout_ready_q <= 1'b0;
      hash_q       <= '0;
      key_q        <= '0;
      busy_q       <= 1'b0;
      send_q       <= 1'b0;
      frame_q      <= '0;
      frame_len_q  <= '0;
`ifdef CMP_MATCH_COUNT_EN
      match_cnt_q  <= '0;
`endif
    end else begin
      dout_ready_q <= dout_ready;
      addr_q       <= addr_nxt;
      diff_q       <= diff_nxt;
      inst_q       <= inst_nxt;
      rd_bank_q    <= bank_nxt;
      dout_q       <= '0;
      if (cmp_start && !cmp_ready_q) cmp_error_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (accept) begin
            tag_q       <= cmp_tag;
            wr_bank_q   <= ~wr_bank_q;
            cmp_ready_q <= 1'b0;
            state_q     <= StStart;
`ifdef CMP_MATCH_COUNT_EN
            match_cnt_q <= '0;
`endif
          end
        end
        StStart: state_q <= StRead;
        StRead: begin
          hash_q  <= ram_rd_q;
          key_q   <= res_rd_q;
          state_q <= StCompare;
        end
        StCompare: begin
          if (!busy_q) begin
            if (search_done && (equal || last)) begin
              busy_q      <= 1'b1;
              send_q      <= 1'b0;
              frame_q     <= frame_nxt;
              frame_len_q <= len_nxt;
`ifdef CMP_MATCH_COUNT_EN
              if (equal) match_cnt_q <= match_cnt_q + CNT_W'(1);
`endif
            end else begin
              // Either the next bsearch step or the next instance.
              state_q <= StRead;
            end
          end else if (emit) begin
            dout_q      <= frame_q[DOUT_WIDTH-1:0];
            frame_q     <= frame_q >> DOUT_WIDTH;
            frame_len_q <= frame_len_q - LEN_W'(1);
            send_q      <= 1'b1;
            if (frame_end) begin
              busy_q <= 1'b0;
              send_q <= 1'b0;
              if (last) begin
                cmp_ready_q <= 1'b1;
                state_q     <= StIdle;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmp_ready = cmp_ready_q;
  assign cmp_error = cmp_error_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_descrypt_cmp.sv
module tb_descrypt_cmp;

  logic        CMP_CLK;
  logic        RST;
  logic        ram_wr_en;
  logic [11:0] ram_wr_addr;
  logic [35:0] ram_wr_data;
  logic [11:0] read_addr_start;
  logic [11:0] addr_diff_start;
  logic        res_wr_en;
  logic [3:0]  res_wr_addr;
  logic [35:0] res_wr_data;
  logic        cmp_start;
  logic [2:0]  cmp_tag;
  logic        cmp_ready;
  logic        dout_ready;
  logic [3:0]  dout;
  logic        cmp_error;

  descrypt_cmp dut (
    .CMP_CLK         (CMP_CLK),
    .RST             (RST),
    .ram_wr_en       (ram_wr_en),
    .ram_wr_addr     (ram_wr_addr),
    .ram_wr_data     (ram_wr_data),
    .read_addr_start (read_addr_start),
    .addr_diff_start (addr_diff_start),
    .res_wr_en       (res_wr_en),
    .res_wr_addr     (res_wr_addr),
    .res_wr_data     (res_wr_data),
    .cmp_start       (cmp_start),
    .cmp_tag         (cmp_tag),
    .cmp_ready       (cmp_ready),
    .dout_ready      (dout_ready),
    .dout            (dout),
    .cmp_error       (cmp_error)
  );

  initial CMP_CLK = 1'b0;
  always #5 CMP_CLK = ~CMP_CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected words plus the length of each expected frame.
  logic [3:0] exp_q[$];
  int         len_q[$];
  int         rem = 0;

  task automatic push_words(input int n, input logic [3:0] w[9]);
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    len_q.push_back(n);
  endtask

  // Model of one frame for the default geometry (IW=4, 12-bit address, 4-bit words).
  task automatic push_frame(input int tag, input int kv, input int eq, input int last,
                            input int inst, input int addr, input int cnt);
    int n;
    n = 2;
    exp_q.push_back(4'((tag << 1) | 1));
    exp_q.push_back(4'((kv << 2) | (eq << 1) | last));
    if (eq != 0) begin
      exp_q.push_back(4'(inst & 15));
      exp_q.push_back(4'(addr & 15));
      exp_q.push_back(4'((addr >> 4) & 15));
      exp_q.push_back(4'((addr >> 8) & 15));
      exp_q.push_back(4'h0);
      n += 5;
    end
`ifdef CMP_MATCH_COUNT_EN
    if (last != 0) begin
      exp_q.push_back(4'(cnt & 15));
      exp_q.push_back(4'((cnt >> 4) & 15));
      n += 2;
    end
`else
    if (cnt < 0) n = 0;
`endif
    len_q.push_back(n);
  endtask

  // A frame starts with a nonzero header word, then runs contiguously.
  always @(negedge CMP_CLK) begin
    if (RST) begin
      rem = 0;
    end else if (rem == 0) begin
      if (dout != 4'h0) begin
        if (len_q.size() == 0) begin
          check("unexpected_word", 64'(dout), 64'h0);
        end else begin
          rem = len_q.pop_front();
          check("dout_word", 64'(dout), 64'(exp_q.pop_front()));
          rem--;
        end
      end
    end else begin
      if (exp_q.size() == 0) check("sb_underflow", 64'(dout), 64'hf0);
      else check("dout_word", 64'(dout), 64'(exp_q.pop_front()));
      rem--;
    end
  end

  task automatic tick();
    @(posedge CMP_CLK);
    #1;
  endtask

  task automatic write_table(input int addr, input logic [35:0] data);
    ram_wr_en   = 1'b1;
    ram_wr_addr = 12'(addr);
    ram_wr_data = data;
    tick();
    ram_wr_en = 1'b0;
  endtask

  // found < 0: no special key; other instances valid-and-absent or invalid.
  task automatic load_batch(input int found, input logic [34:0] fhash, input bit others_valid);
    for (int i = 0; i < 16; i++) begin
      res_wr_en   = 1'b1;
      res_wr_addr = 4'(i);
      if (i == found)        res_wr_data = {1'b1, fhash};
      else if (others_valid) res_wr_data = {1'b1, 35'h1000 + 35'(i)};
      else                   res_wr_data = {1'b0, 35'h1000 + 35'(i)};
      tick();
    end
    res_wr_en = 1'b0;
  endtask

  task automatic start_batch(input int tag);
    cmp_start = 1'b1;
    cmp_tag   = 3'(tag);
    tick();
    cmp_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (cmp_ready) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 64'h0, 64'h1);
    tick();
    tick();
    check({tag, "_sb_words_left"}, 64'(exp_q.size()), 64'h0);
    check({tag, "_sb_frames_left"}, 64'(len_q.size()), 64'h0);
  endtask

  initial begin
    logic [3:0] w[9];
    bit seen;

    RST = 1'b1;
    ram_wr_en = 1'b0; ram_wr_addr = '0; ram_wr_data = '0;
    read_addr_start = 12'd7; addr_diff_start = 12'd4;
    res_wr_en = 1'b0; res_wr_addr = '0; res_wr_data = '0;
    cmp_start = 1'b0; cmp_tag = '0; dout_ready = 1'b1;
    tick(); tick();
    check("rst_cmp_ready", 64'(cmp_ready), 64'h1);
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_cmp_error", 64'(cmp_error), 64'h0);
    RST = 1'b0;
    tick();

    // Table: only 3, 5, 7 valid over the region the search can reach.
    for (int a = 0; a < 16; a++) write_table(a, 36'h0);
    write_table(3, {1'b1, 35'h100});
    write_table(5, {1'b1, 35'h123});
    write_table(7, {1'b1, 35'h200});

    // Match at instance 2, final frame at instance 15.
    load_batch(2, 35'h123, 1'b1);
    w = '{4'hB, 4'h6, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    push_words(7, w);
`ifdef CMP_MATCH_COUNT_EN
    w = '{4'hB, 4'h5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    push_words(4, w);
`else
    w = '{4'hB, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    push_words(2, w);
`endif
    start_batch(5);
    check("busy_cmp_ready", 64'(cmp_ready), 64'h0);
    wait_done("match_batch");

    // All keys invalid: a single final frame.
    load_batch(-1, 35'h0, 1'b0);
    push_frame(2, 0, 0, 1, 15, 0, 0);
    start_batch(2);
    wait_done("invalid_batch");
    check("invalid_cmp_ready", 64'(cmp_ready), 64'h1);
    check("no_error_yet", 64'(cmp_error), 64'h0);

    // Start while busy: error flagged, first batch unaffected.
    load_batch(9, 35'h100, 1'b0);
    push_frame(3, 1, 1, 0, 9, 3, 0);
    push_frame(3, 0, 0, 1, 15, 0, 1);
    start_batch(3);
    tick();
    start_batch(6);
    check("busy_start_error", 64'(cmp_error), 64'h1);
    wait_done("busy_batch");

    // Backpressure: frame held while dout_ready is low, then sent intact.
    dout_ready = 1'b0;
    load_batch(0, 35'h200, 1'b0);
    push_frame(6, 1, 1, 0, 0, 7, 0);
    push_frame(6, 0, 0, 1, 15, 0, 1);
    start_batch(6);
    for (int i = 0; i < 20; i++) tick();
    check("stall_dout", 64'(dout), 64'h0);
    check("stall_frames_pending", 64'(len_q.size()), 64'h2);
    check("stall_cmp_ready", 64'(cmp_ready), 64'h0);
    dout_ready = 1'b1;
    wait_done("stall_batch");

    // Reset in the middle of a frame.
    load_batch(0, 35'h200, 1'b0);
    push_frame(4, 1, 1, 0, 0, 7, 0);
    push_frame(4, 0, 0, 1, 15, 0, 1);
    start_batch(4);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (dout != 4'h0) seen = 1'b1;
    end
    check("mid_frame_seen", 64'(seen), 64'h1);
    RST = 1'b1;
    #1;
    check("rst_mid_dout", 64'(dout), 64'h0);
    check("rst_mid_cmp_ready", 64'(cmp_ready), 64'h1);
    check("rst_mid_cmp_error", 64'(cmp_error), 64'h0);
    exp_q.delete();
    len_q.delete();
    tick(); tick();
    RST = 1'b0;
    tick();

    // Fresh batch after reset; the table survives reset.
    load_batch(1, 35'h123, 1'b1);
    push_frame(1, 1, 1, 0, 1, 5, 0);
    push_frame(1, 1, 0, 1, 15, 0, 1);
    start_batch(1);
    wait_done("post_reset_batch");
    check("final_dout", 64'(dout), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
